app_us_timer: RTL and testbench

- Microsecond-resolution delay timer with request/acknowledge/done handshake.
- A client raises I_app_req with a delay in µs. The block acknowledges, holds busy for the delay (clock-cycle exact), then pulses done.
- Optional auto-reload (LOOP) gives a periodic µs tick generator.
- Used by higher-level controllers for wait states (power-up delays, protocol gaps).

---
 rtl/app_us_timer_if.sv | 46 ++++
 rtl/app_us_timer.sv | 145 ++++++++++++++
 tb/tb_app_us_timer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/app_us_timer_if.sv
// Client/timer handshake bundle: request level plus delay in, busy/ack/done pulses out.
// With TIMER_REMAIN_EN defined the bundle also carries the remaining-µs readout.
interface app_us_timer_if;
  logic [31:0] I_app_timer_us;
  logic        I_app_req;
  logic        O_app_busy;
  logic        O_app_ack;
  logic        O_app_done;
`ifdef TIMER_REMAIN_EN
  logic [31:0] O_app_remain_us;

  modport master (
    output I_app_timer_us,
    output I_app_req,
    input  O_app_busy,
    input  O_app_ack,
    input  O_app_done,
    input  O_app_remain_us
  );

  modport slave (
    input  I_app_timer_us,
    input  I_app_req,
    output O_app_busy,
    output O_app_ack,
    output O_app_done,
    output O_app_remain_us
  );
`else
  modport master (
    output I_app_timer_us,
    output I_app_req,
    input  O_app_busy,
    input  O_app_ack,
    input  O_app_done
  );

  modport slave (
    input  I_app_timer_us,
    input  I_app_req,
    output O_app_busy,
    output O_app_ack,
    output O_app_done
  );
`endif
endinterface

// File: rtl/app_us_timer.sv
// µs delay timer: ack one cycle after a request edge, done max(N,1)*CLK_FRE cycles after ack.
// No backpressure; edges seen while running are dropped. TIMER_REMAIN_EN adds O_app_remain_us.
module app_us_timer #(
  parameter int CLK_FRE = 50,
  parameter int LOOP    = 0
) (
  input  logic            I_Clk,
  input  logic            I_rst_n,
  app_us_timer_if.slave   app
);

  localparam int PW = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FRE - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic          req_dly_q, req_dly_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   us_cnt_q, us_cnt_d;
  logic [31:0]   n_q, n_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
`ifdef TIMER_REMAIN_EN
  logic [31:0]   remain_q, remain_d;
  logic [31:0]   remain_base;
`endif

  logic          req_edge;
  logic          reload;
  logic          leaving;
  logic          wrap;
  logic          hit;
  logic [31:0]   n_in;
  logic [31:0]   n_cmp;
  logic          busy;

  function automatic logic [31:0] clamp_n(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  always_ff @(posedge I_Clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= ST_IDLE;
      req_dly_q <= 1'b0;
      presc_q   <= '0;
      us_cnt_q  <= '0;
      n_q       <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef TIMER_REMAIN_EN
      remain_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_dly_q <= req_dly_d;
      presc_q   <= presc_d;
      us_cnt_q  <= us_cnt_d;
      n_q       <= n_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
`ifdef TIMER_REMAIN_EN
      remain_q  <= remain_d;
`endif
    end
  end

  // The done cycle doubles as cycle 0 of the next period: the final wrap
  // clears the µs counter, so a reload only needs to re-latch N.
  always_comb begin
    req_edge  = app.I_app_req & ~req_dly_q;
    n_in      = clamp_n(app.I_app_timer_us);
    reload    = (LOOP != 0) && done_q && app.I_app_req;
    leaving   = done_q && !reload;
    n_cmp     = reload ? n_in : n_q;
    wrap      = (presc_q == PRE_MAX);
    hit       = (state_q == ST_RUN) && !leaving && wrap && (us_cnt_q == n_cmp - 32'd1);

    state_d   = state_q;
    req_dly_d = app.I_app_req;
    presc_d   = presc_q;
    us_cnt_d  = us_cnt_q;
    n_d       = n_q;
    ack_d     = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          state_d  = ST_RUN;
          n_d      = n_in;
          presc_d  = '0;
          us_cnt_d = '0;
          ack_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (leaving) begin
          state_d  = ST_IDLE;
          presc_d  = '0;
          us_cnt_d = '0;
          n_d      = '0;
        end else begin
          n_d     = n_cmp;
          presc_d = wrap ? '0 : presc_q + PW'(1);
          if (hit) begin
            done_d   = 1'b1;
            us_cnt_d = '0;
          end else if (wrap) begin
            us_cnt_d = us_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef TIMER_REMAIN_EN
  always_comb begin
    remain_base = reload ? n_in : remain_q;
    remain_d    = '0;
    if (state_q == ST_IDLE) begin
      remain_d = req_edge ? n_in : 32'd0;
    end else if (!leaving) begin
      if (hit)
        remain_d = '0;
      else if (wrap)
        remain_d = remain_base - 32'd1;
      else
        remain_d = remain_base;
    end
  end

  assign app.O_app_remain_us = remain_q;
`endif

  always_comb begin
    busy = (state_q == ST_RUN);
  end

  assign app.O_app_busy = busy;
  assign app.O_app_ack  = ack_q;
  assign app.O_app_done = done_q;

endmodule

// File: tb/tb_app_us_timer.sv
// Directed bench for app_us_timer: one-shot and auto-reload instances at CLK_FRE=50.
module tb_app_us_timer;

  logic I_Clk = 1'b0;
  logic I_rst_n;

  always #5 I_Clk = ~I_Clk;

  app_us_timer_if if0();
  app_us_timer_if if1();

  app_us_timer #(.CLK_FRE(50), .LOOP(0)) dut0 (
    .I_Clk   (I_Clk),
    .I_rst_n (I_rst_n),
    .app     (if0.slave)
  );

  app_us_timer #(.CLK_FRE(50), .LOOP(1)) dut1 (
    .I_Clk   (I_Clk),
    .I_rst_n (I_rst_n),
    .app     (if1.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          sel;      // 0: one-shot DUT, 1: auto-reload DUT
    logic [31:0] n;
    int          mode;     // 0 hold req, 1 drop req at ack, 2 toggle req mid-run
    int          exp_gap;  // ack-to-done cycles
    int          exp_busy; // busy cycles
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic get_ack(input bit sel);
    return sel ? if1.O_app_ack : if0.O_app_ack;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? if1.O_app_done : if0.O_app_done;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? if1.O_app_busy : if0.O_app_busy;
  endfunction

  task automatic set_req(input bit sel, input logic v);
    if (sel) if1.I_app_req = v;
    else     if0.I_app_req = v;
  endtask

  task automatic set_n(input bit sel, input logic [31:0] v);
    if (sel) if1.I_app_timer_us = v;
    else     if0.I_app_timer_us = v;
  endtask

  task automatic wait_ack(input bit sel, output int t);
    t = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge I_Clk);
      if (get_ack(sel)) begin
        t = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input bit sel, input logic [31:0] n, input int mode,
                         input int exp_gap, input int exp_busy);
    int t_ack, t_done, busy_cnt, acks, overlap, extra_done;
    set_n(sel, n);
    set_req(sel, 1'b1);
    wait_ack(sel, t_ack);
    chk({name, "_ack_latency"}, t_ack, 0);
    if (t_ack < 0) begin
      set_req(sel, 1'b0);
      return;
    end
    acks = 1; busy_cnt = 0; overlap = 0; t_done = -1; extra_done = 0;
    if (mode == 1) set_req(sel, 1'b0);
    for (int k = 0; k < exp_gap + 100; k++) begin
      if (k > 0) @(negedge I_Clk);
      if (k > 0 && get_ack(sel)) acks++;
      if (get_ack(sel) && get_done(sel)) overlap++;
      if (get_busy(sel)) busy_cnt++;
      if (mode == 2 && k >= 10 && k < 20) set_req(sel, k[0]);
      if (get_done(sel)) begin
        t_done = k;
        break;
      end
    end
    chk({name, "_done_gap"}, t_done, exp_gap);
    for (int k = 0; k < 20; k++) begin
      @(negedge I_Clk);
      if (get_busy(sel)) busy_cnt++;
      if (get_ack(sel)) acks++;
      if (get_done(sel)) extra_done++;
    end
    chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({name, "_ack_count"}, acks, 1);
    chk({name, "_ack_done_overlap"}, overlap, 0);
    chk({name, "_extra_done"}, extra_done, 0);
    set_req(sel, 1'b0);
    @(negedge I_Clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int nd, busy_low, extra_ack, rst_done;
    int exp_d[5];

    vecs[0] = '{1'b0, 32'd1, 0,  50,  51};
    vecs[1] = '{1'b0, 32'd0, 0,  50,  51};
    vecs[2] = '{1'b0, 32'd3, 2, 150, 151};
    vecs[3] = '{1'b0, 32'd3, 0, 150, 151};
    vecs[4] = '{1'b0, 32'd7, 0, 350, 351};
    vecs[5] = '{1'b1, 32'd2, 1, 100, 101};
    vecs[6] = '{1'b1, 32'd0, 1,  50,  51};
    exp_d = '{100, 200, 250, 300, 350};

    // Reset with the one-shot request already high.
    I_rst_n = 1'b0;
    if0.I_app_req = 1'b1; if0.I_app_timer_us = 32'd10;
    if1.I_app_req = 1'b0; if1.I_app_timer_us = 32'd0;
    repeat (3) @(negedge I_Clk);
    chk("rst_busy0", if0.O_app_busy, 0);
    chk("rst_ack0",  if0.O_app_ack,  0);
    chk("rst_done0", if0.O_app_done, 0);
    chk("rst_busy1", if1.O_app_busy, 0);
    chk("rst_ack1",  if1.O_app_ack,  0);
    chk("rst_done1", if1.O_app_done, 0);
`ifdef TIMER_REMAIN_EN
    chk("rst_remain0", if0.O_app_remain_us, 0);
`endif
    I_rst_n = 1'b1;
    run_vec("rst_release_n10", 1'b0, 32'd10, 0, 500, 501);

    for (int i = 0; i < 7; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].sel, vecs[i].n, vecs[i].mode,
              vecs[i].exp_gap, vecs[i].exp_busy);

    // Auto-reload: N changed mid-period only takes effect at the next reload.
    set_n(1'b1, 32'd2);
    set_req(1'b1, 1'b1);
    wait_ack(1'b1, t);
    chk("loop_ack_latency", t, 0);
    nd = 0; busy_low = 0; extra_ack = 0;
    for (int k = 0; k <= 420; k++) begin
      if (k > 0) @(negedge I_Clk);
      if (k == 130) set_n(1'b1, 32'd1);
      if (k == 320) set_req(1'b1, 1'b0);
      if (k <= 350 && !get_busy(1'b1)) busy_low++;
      if (k > 0 && get_ack(1'b1)) extra_ack++;
      if (get_done(1'b1)) begin
        if (nd < 5) chk($sformatf("loop_done%0d_time", nd), k, exp_d[nd]);
        nd++;
      end
      if (k == 351) chk("loop_busy_after_last", get_busy(1'b1), 0);
    end
    chk("loop_done_count", nd, 5);
    chk("loop_busy_gaps", busy_low, 0);
    chk("loop_extra_ack", extra_ack, 0);

    // Reset 200 cycles into an N=10 run.
    set_n(1'b0, 32'd10);
    set_req(1'b0, 1'b1);
    wait_ack(1'b0, t);
    chk("midrst_ack_latency", t, 0);
    repeat (200) @(negedge I_Clk);
    chk("midrst_busy_before", if0.O_app_busy, 1);
    I_rst_n = 1'b0;
    #1;
    chk("midrst_busy", if0.O_app_busy, 0);
    chk("midrst_ack",  if0.O_app_ack,  0);
    chk("midrst_done", if0.O_app_done, 0);
    rst_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge I_Clk);
      if (if0.O_app_done || if0.O_app_busy) rst_done++;
    end
    chk("midrst_quiet", rst_done, 0);
    I_rst_n = 1'b1;
    run_vec("midrst_rerun_n10", 1'b0, 32'd10, 0, 500, 501);

`ifdef TIMER_REMAIN_EN
    set_n(1'b0, 32'd4);
    set_req(1'b0, 1'b1);
    wait_ack(1'b0, t);
    chk("remain_ack_latency", t, 0);
    for (int k = 0; k <= 202; k++) begin
      if (k > 0) @(negedge I_Clk);
      if (k == 0)   chk("remain_k0",   if0.O_app_remain_us, 4);
      if (k == 49)  chk("remain_k49",  if0.O_app_remain_us, 4);
      if (k == 50)  chk("remain_k50",  if0.O_app_remain_us, 3);
      if (k == 100) chk("remain_k100", if0.O_app_remain_us, 2);
      if (k == 150) chk("remain_k150", if0.O_app_remain_us, 1);
      if (k == 199) chk("remain_k199", if0.O_app_remain_us, 1);
      if (k == 200) chk("remain_done", if0.O_app_done, 1);
      if (k == 201) chk("remain_idle", if0.O_app_remain_us, 0);
    end
    set_req(1'b0, 1'b0);
    @(negedge I_Clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
